// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter.
// State encodings equal the one-hot grant vector {m1,m0}, so the state register is gnt_o.
package wb_arb_pkg;

  localparam int WB_ARB_ADDR_W = 32;
  localparam int WB_ARB_DATA_W = 32;

  typedef enum logic [1:0] {
    WB_ARB_IDLE   = 2'b00,
    WB_ARB_OWN_M0 = 2'b01,
    WB_ARB_OWN_M1 = 2'b10
  } wb_arb_state_t;

endpackage

// File: rtl/wb_arb_pick.sv
// Tie-break for the arbiter's IDLE state; round-robin when WB_ARB_RR_EN is defined, else m1 wins.
// Latency: combinational. Backpressure: none, pure function of the requests and the pointer.
// Config macro: WB_ARB_RR_EN.
module wb_arb_pick (
  input  logic m0_cyc,
  input  logic m1_cyc,
  input  logic last_m1,
  output logic pick_m1
);

`ifdef WB_ARB_RR_EN
  // On a tie, the master not served last wins.
  assign pick_m1 = (m0_cyc & m1_cyc) ? ~last_m1 : m1_cyc;
`else
  logic unused_pick_in;
  assign unused_pick_in = m0_cyc ^ last_m1;
  assign pick_m1        = m1_cyc;
`endif

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter; grant held for the owner's whole cyc. Config macro: WB_ARB_RR_EN.
// Latency: grant registered on the edge that samples cyc; ack and read data return combinationally.
// Backpressure: a non-owning master simply waits without ack; no timeout is imposed on the owner.
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter  int ADDR_W = WB_ARB_ADDR_W,
  parameter  int DATA_W = WB_ARB_DATA_W,
  localparam int SEL_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_we_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_we_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_we_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  wb_arb_state_t state;
  logic          last_m1;
  logic          pick_m1;
  logic          go_m0, go_m1, go_idle;
  logic          own_m0, own_m1;

  wb_arb_pick u_pick (
    .m0_cyc  (m0_cyc_i),
    .m1_cyc  (m1_cyc_i),
    .last_m1 (last_m1),
    .pick_m1 (pick_m1)
  );

  // Transition decode shared by the FSM and the round-robin pointer.
  always_comb begin
    go_m0   = 1'b0;
    go_m1   = 1'b0;
    go_idle = 1'b0;
    case (state)
      WB_ARB_IDLE: begin
        go_m1 = (m0_cyc_i | m1_cyc_i) & pick_m1;
        go_m0 = (m0_cyc_i | m1_cyc_i) & ~pick_m1;
      end
      WB_ARB_OWN_M0: begin
        go_m1   = ~m0_cyc_i & m1_cyc_i;
        go_idle = ~m0_cyc_i & ~m1_cyc_i;
      end
      WB_ARB_OWN_M1: begin
        go_m0   = ~m1_cyc_i & m0_cyc_i;
        go_idle = ~m1_cyc_i & ~m0_cyc_i;
      end
      default: go_idle = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WB_ARB_IDLE;
    end else if (go_m1) begin
      state <= WB_ARB_OWN_M1;
    end else if (go_m0) begin
      state <= WB_ARB_OWN_M0;
    end else if (go_idle) begin
      state <= WB_ARB_IDLE;
    end
  end

`ifdef WB_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1 <= 1'b0;
    end else if (go_m1) begin
      last_m1 <= 1'b1;
    end else if (go_m0) begin
      last_m1 <= 1'b0;
    end
  end
`else
  assign last_m1 = 1'b0;
`endif

  assign own_m0 = (state == WB_ARB_OWN_M0);
  assign own_m1 = (state == WB_ARB_OWN_M1);
  assign gnt_o  = state;

  always_comb begin
    s_addr_o = '0;
    s_data_o = '0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    if (own_m0) begin
      s_addr_o = m0_addr_i;
      s_data_o = m0_data_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_stb_o  = m0_stb_i;
      s_cyc_o  = m0_cyc_i;
    end else if (own_m1) begin
      s_addr_o = m1_addr_i;
      s_data_o = m1_data_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_stb_o  = m1_stb_i;
      s_cyc_o  = m1_cyc_i;
    end
  end

  // Gating ack with the owner's own cyc keeps a late slave ack from leaking across a handover.
  assign m0_ack_o  = s_ack_i & own_m0 & m0_cyc_i;
  assign m1_ack_o  = s_ack_i & own_m1 & m1_cyc_i;
  assign m0_data_o = own_m0 ? s_data_i : '0;
  assign m1_data_o = own_m1 ? s_data_i : '0;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: vector table plus contention, async-reset and alternation sequences.
module tb_wb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wdat, m0_rdat, m1_addr, m1_wdat, m1_rdat;
  logic        m0_we, m0_stb, m0_cyc, m0_ack, m1_we, m1_stb, m1_cyc, m1_ack;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic [31:0] s_addr, s_wdat, s_rdat;
  logic        s_we, s_stb, s_cyc, s_ack;
  logic [1:0]  gnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign m0_stb = m0_cyc;
  assign m1_stb = m1_cyc;

  wb_bus_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_addr_i (m0_addr),
    .m0_data_i (m0_wdat),
    .m0_we_i   (m0_we),
    .m0_sel_i  (m0_sel),
    .m0_stb_i  (m0_stb),
    .m0_cyc_i  (m0_cyc),
    .m0_data_o (m0_rdat),
    .m0_ack_o  (m0_ack),
    .m1_addr_i (m1_addr),
    .m1_data_i (m1_wdat),
    .m1_we_i   (m1_we),
    .m1_sel_i  (m1_sel),
    .m1_stb_i  (m1_stb),
    .m1_cyc_i  (m1_cyc),
    .m1_data_o (m1_rdat),
    .m1_ack_o  (m1_ack),
    .s_addr_o  (s_addr),
    .s_data_o  (s_wdat),
    .s_we_o    (s_we),
    .s_sel_o   (s_sel),
    .s_stb_o   (s_stb),
    .s_cyc_o   (s_cyc),
    .s_data_i  (s_rdat),
    .s_ack_i   (s_ack),
    .gnt_o     (gnt)
  );

`ifdef WB_ARB_RR_EN
  localparam logic [1:0] TIE2_GNT = 2'b01;
`else
  localparam logic [1:0] TIE2_GNT = 2'b10;
`endif

  typedef struct {
    logic        rst;
    logic        c0;
    logic        c1;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  gnt;
    logic        s_cyc;
    logic        s_we;
    logic [31:0] s_addr;
    logic        m0_ack;
    logic        m1_ack;
    logic [31:0] m0_dat;
    logic [31:0] m1_dat;
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(logic r, logic c0, logic c1, logic ack, logic [31:0] sd,
                              logic [1:0] g, logic a0, logic a1,
                              logic [31:0] d0, logic [31:0] d1);
    vec_t v;
    v.rst = r; v.c0 = c0; v.c1 = c1; v.ack = ack; v.sdat = sd;
    v.gnt = g; v.m0_ack = a0; v.m1_ack = a1; v.m0_dat = d0; v.m1_dat = d1;
    v.s_cyc  = (g != 2'b00);
    v.s_we   = (g == 2'b10);
    v.s_addr = (g == 2'b01) ? 32'h0000_0100 : (g == 2'b10) ? 32'h3000_0000 : 32'h0;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_g;

    m0_addr = 32'h0000_0100; m0_wdat = 32'hAAAA_5555; m0_we = 1'b0; m0_sel = 4'b1111;
    m1_addr = 32'h3000_0000; m1_wdat = 32'h1234_5678; m1_we = 1'b1; m1_sel = 4'b1111;
    rst = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0; s_rdat = '0;

    //             rst  c0    c1    ack   sdat           gnt    a0    a1    m0_dat         m1_dat
    vec[0]  = mk(1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 2'b00, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[1]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0BAD_F00D, 2'b10, 1'b0, 1'b0, 32'h0,         32'h0BAD_F00D);
    vec[2]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 2'b10, 1'b0, 1'b1, 32'h0,         32'h1111_1111);
    vec[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[4]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'b01, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
    vec[5]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[6]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[8]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         2'b01, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[9]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 32'h2222_2222, 2'b01, 1'b1, 1'b0, 32'h2222_2222, 32'h0);
    vec[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         2'b10, 1'b0, 1'b0, 32'h0,         32'h0);
    vec[11] = mk(1'b1, 1'b0, 1'b1, 1'b1, 32'h3333_3333, 2'b10, 1'b0, 1'b1, 32'h0,         32'h3333_3333);
    vec[12] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 32'h0,         32'h0);
    // Second IDLE tie: last grant went to m1, so round-robin favours m0.
    vec[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         TIE2_GNT, 1'b0, 1'b0, 32'h0,      32'h0);

    #2;
    for (int i = 0; i < 14; i++) begin
      rst = vec[i].rst; m0_cyc = vec[i].c0; m1_cyc = vec[i].c1;
      s_ack = vec[i].ack; s_rdat = vec[i].sdat;
      tick();
      chk($sformatf("v%0d_gnt", i),    {30'h0, gnt},     {30'h0, vec[i].gnt});
      chk($sformatf("v%0d_s_cyc", i),  {31'h0, s_cyc},   {31'h0, vec[i].s_cyc});
      chk($sformatf("v%0d_s_stb", i),  {31'h0, s_stb},   {31'h0, vec[i].s_cyc});
      chk($sformatf("v%0d_s_we", i),   {31'h0, s_we},    {31'h0, vec[i].s_we});
      chk($sformatf("v%0d_s_addr", i), s_addr,           vec[i].s_addr);
      chk($sformatf("v%0d_m0_ack", i), {31'h0, m0_ack},  {31'h0, vec[i].m0_ack});
      chk($sformatf("v%0d_m1_ack", i), {31'h0, m1_ack},  {31'h0, vec[i].m1_ack});
      chk($sformatf("v%0d_m0_dat", i), m0_rdat,          vec[i].m0_dat);
      chk($sformatf("v%0d_m1_dat", i), m1_rdat,          vec[i].m1_dat);
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0; s_ack = 1'b0; s_rdat = '0;
    tick();
    chk("idle_after_table", {30'h0, gnt}, 32'h0);

    // Contention: m0 read with three wait states, m1 write arrives mid-transfer.
    m0_cyc = 1'b1;
    tick();
    chk("cont_gnt_m0", {30'h0, gnt}, 32'h1);
    m1_cyc = 1'b1;
    for (int w = 0; w < 3; w++) begin
      tick();
      chk($sformatf("cont_wait%0d_gnt", w), {30'h0, gnt}, 32'h1);
      chk($sformatf("cont_wait%0d_m1_ack", w), {31'h0, m1_ack}, 32'h0);
    end
    s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
    #1;
    chk("cont_m0_ack", {31'h0, m0_ack}, 32'h1);
    chk("cont_m0_dat", m0_rdat, 32'hCAFE_F00D);
    chk("cont_m1_ack_blocked", {31'h0, m1_ack}, 32'h0);
    tick();
    m0_cyc = 1'b0;
    #1;
    chk("cont_gap_s_cyc", {31'h0, s_cyc}, 32'h0);
    chk("cont_gap_m0_ack", {31'h0, m0_ack}, 32'h0);
    chk("cont_gap_m1_ack", {31'h0, m1_ack}, 32'h0);
    chk("cont_gap_gnt", {30'h0, gnt}, 32'h1);
    tick();
    s_ack = 1'b0;
    #1;
    chk("cont_m1_gnt", {30'h0, gnt}, 32'h2);
    chk("cont_m1_s_cyc", {31'h0, s_cyc}, 32'h1);
    chk("cont_m1_s_we", {31'h0, s_we}, 32'h1);
    chk("cont_m1_s_sel", {28'h0, s_sel}, 32'hF);
    chk("cont_m1_s_addr", s_addr, 32'h3000_0000);
    chk("cont_m1_s_data", s_wdat, 32'h1234_5678);
    s_ack = 1'b1;
    #1;
    chk("cont_m1_ack", {31'h0, m1_ack}, 32'h1);
    tick();
    m1_cyc = 1'b0; s_ack = 1'b0;
    tick();
    chk("cont_end_idle", {30'h0, gnt}, 32'h0);

    // Async reset while m0 owns the bus with stb high and the slave acking.
    m0_cyc = 1'b1;
    tick();
    chk("arst_pre_gnt", {30'h0, gnt}, 32'h1);
    chk("arst_pre_stb", {31'h0, s_stb}, 32'h1);
    #2;
    s_ack = 1'b1;
    rst   = 1'b0;
    #1;
    chk("arst_s_cyc", {31'h0, s_cyc}, 32'h0);
    chk("arst_s_stb", {31'h0, s_stb}, 32'h0);
    chk("arst_m0_ack", {31'h0, m0_ack}, 32'h0);
    chk("arst_gnt", {30'h0, gnt}, 32'h0);
    m0_cyc = 1'b0; s_ack = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    chk("arst_release_idle", {30'h0, gnt}, 32'h0);

    // Both request continuously: handovers alternate starting with m1 after reset.
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    tick();
    exp_g = 2'b10;
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("alt%0d_gnt", t), {30'h0, gnt}, {30'h0, exp_g});
      s_ack = 1'b1;
      #1;
      chk($sformatf("alt%0d_ack", t), {30'h0, m1_ack, m0_ack}, {30'h0, exp_g});
      tick();
      s_ack = 1'b0;
      if (exp_g == 2'b10) m1_cyc = 1'b0;
      else                m0_cyc = 1'b0;
      tick();
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      exp_g = {exp_g[0], exp_g[1]};
    end
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    tick();
    chk("alt_end_idle", {30'h0, gnt}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
